fib_seq_checker: RTL and testbench
==================================

# fib_seq_checker

Consumer-side companion to the 11-bit Fibonacci generator. It samples a stream of terms on a valid strobe and checks term 0 and term 1 against the seeds. It then checks every later term against the sum of the two terms before it. After the configured number of terms, or at the first mismatch, it reports pass/fail. It sits on the generator's data output, either on the board or in the system bench, and drives the pass/fail LEDs.

## Interface
- `W`, default 11: term width in bits.
- `N_TERMS`, default 16: number of terms checked per run. Must be ≥ 3.
- `CW`, default `$clog2(N_TERMS+1)`, derived (not overridden): width of the count and index outputs.

Ports:
- `CLK` input 1: system clock. Every register updates on the rising edge.
- `RST_N` input 1: reset, synchronous, active-low.
- `START` input 1: level-sampled. Begins a new run; also restarts a run already in progress.
- `VALID` input 1: `DATA_IN` holds a term this cycle.
- `DATA_IN` input W: the term under test.
- `BUSY` output 1: high while in CHECK.
- `DONE` output 1: one-cycle pulse when a run finishes.
- `PASS` output 1: the last run checked all `N_TERMS` terms with no mismatch. Holds until the next `START`.
- `ERR` output 1: the last run hit a mismatch. Holds until the next `START`.
- `ERR_IDX` output CW: index (0-based) of the first mismatching term. Valid while `ERR`=1.
- `COUNT` output CW: terms accepted in the current or last run.

## Operation
- Internal state: registers `prev1` and `prev2` (W bits each), `idx` (CW bits), and the FSM.
- FSM has three states: IDLE, CHECK, REPORT.
- IDLE:
  - `VALID` is ignored.
  - `START`=1 moves to CHECK and clears `idx`, `COUNT`, `PASS`, `ERR`, `ERR_IDX`, `prev1` and `prev2`.
- CHECK, on each cycle with `VALID`=1:
  - idx 0: expected value is 0.
  - idx 1: expected value is 1.
  - idx ≥ 2: expected value is `prev1 + prev2`, computed W+1 bits wide. A carry-out is always a mismatch; the sum never wraps.
  - On match: shift `prev2`←`prev1` and `prev1`←`DATA_IN`, then increment `idx` and `COUNT`. If this was term `N_TERMS-1`, set `PASS` and go to REPORT.
  - On mismatch: set `ERR`, set `ERR_IDX`←`idx`, leave `COUNT` unchanged, and go to REPORT. Later beats in the run are not examined.
- CHECK, other events:
  - `VALID`=0 cycles hold all state. Gaps of any length are allowed.
  - `START`=1 restarts the run, clearing as on entry from IDLE. `START` takes priority over a `VALID` beat in the same cycle, and that beat is discarded.
- REPORT lasts one cycle: `DONE`=1, then go to IDLE. `VALID` is ignored. `START` in REPORT takes effect from IDLE on the following cycle.
- `BUSY`=1 only in CHECK.

## Timing
- On reset (`RST_N`=0 at a rising edge): state IDLE, and every output (`BUSY`, `DONE`, `PASS`, `ERR`, `ERR_IDX`, `COUNT`) is 0.
- Reset mid-run aborts the run. No `DONE` is issued.
- The `START` edge enters CHECK, and `BUSY`=1 from the next cycle. The earliest accepted beat is the cycle after `START`.
- Verdict latency: `PASS`/`ERR` are registered at the edge that samples the deciding beat. `DONE` is high for the cycle after that beat, coincident with the verdict being visible.
- Minimum run time: `N_TERMS` beats, plus one cycle in REPORT.
- Throughput: one term per cycle when `VALID` is held high.

## Configuration
- `FIB_CHK_SEED_EN`:
  - Defined: seed checking is compiled out. Terms 0 and 1 are accepted as any value and loaded into the history. Only the recurrence is checked from idx 2 onward, so the checker works on generators with arbitrary seeds.
  - Undefined (default): term 0 must be 0 and term 1 must be 1, as in Operation.

## Test plan
- Reset: assert `RST_N`=0 during a run → the next cycle all outputs are 0 and the FSM is in IDLE. `VALID` beats in IDLE change nothing.
- Good stream: `START`, then 0,1,1,2,3,5,8,13,21,34,55,89,144,233,377,610 with random `VALID` gaps → `DONE` pulses for one cycle after 610, with `PASS`=1, `ERR`=0, `COUNT`=16.
- Corrupt term: the same stream with idx 7 sent as 14 instead of 13 → `DONE` the cycle after that beat, `ERR`=1, `ERR_IDX`=7, `COUNT`=7. Later beats are ignored and `BUSY`=0.
- Overflow: `W`=11 with `N_TERMS`=19, sending 2584 mod 2048 = 536 at idx 18 → `ERR`=1, `ERR_IDX`=18.
- Restart: `START` again after 5 good beats, together with a `VALID` beat → that beat is dropped, `COUNT`=0, and a fresh 16-term run then passes.
- Seeds: stream 2,3,5,8,… for 16 terms → with `FIB_CHK_SEED_EN`, `PASS`=1. Without it, `ERR`=1 and `ERR_IDX`=0.

Source files
------------

// File: rtl/fib_seq_checker.sv
// fib_seq_checker
//   Consumer-side checker for a W-bit Fibonacci term stream. After START it
//   samples terms on VALID. Term 0 must be 0 and term 1 must be 1. Every
//   later term must equal the sum of the two terms before it, and that sum
//   must not carry out of W bits. The run ends after N_TERMS good terms or
//   at the first mismatch. DONE then pulses for one cycle, and PASS/ERR hold
//   until the next START.
//
// Parameters
//   W        term width
//   N_TERMS  terms per run (>= 3)
//   CW       derived width of COUNT / ERR_IDX
//
// Ports
//   CLK      rising-edge clock
//   RST_N    synchronous active-low reset
//   START    begin or restart a run (level-sampled)
//   VALID    DATA_IN carries a term this cycle
//   DATA_IN  term under test
//   BUSY     high while checking
//   DONE     one-cycle pulse when a run finishes
//   PASS     last run checked all N_TERMS terms cleanly
//   ERR      last run hit a mismatch
//   ERR_IDX  0-based index of the first mismatching term
//   COUNT    terms accepted in the current or last run
//
// Build option
//   FIB_CHK_SEED_EN  when defined, terms 0 and 1 are accepted as any value
//                    and only the recurrence is checked.
module fib_seq_checker #(
  parameter int W       = 11,
  parameter int N_TERMS = 16,
  localparam int CW     = $clog2(N_TERMS + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          VALID,
  input  logic [W-1:0]  DATA_IN,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic          ERR,
  output logic [CW-1:0] ERR_IDX,
  output logic [CW-1:0] COUNT
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  prev1;
  logic [W-1:0]  prev2;
  logic [CW-1:0] idx;
  logic [CW-1:0] err_idx;
  logic          pass_r;
  logic          err_r;
  logic          beat_ok;
  logic          clear;
  logic          beat;

  // Sum kept one bit wider so a carry-out can never compare equal to a
  // W-bit term.
  function automatic logic [W:0] fib_sum(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  always_comb begin
    beat_ok = ({1'b0, DATA_IN} == fib_sum(prev1, prev2));
`ifdef FIB_CHK_SEED_EN
    if (idx < CW'(2)) beat_ok = 1'b1;
`else
    if (idx == CW'(0))      beat_ok = (DATA_IN == W'(0));
    else if (idx == CW'(1)) beat_ok = (DATA_IN == W'(1));
`endif
  end

  // START wins over a same-cycle beat; beats outside CHECK are ignored.
  assign clear = START && ((state == S_IDLE) || (state == S_CHECK));
  assign beat  = (state == S_CHECK) && !START && VALID;

  // Control: FSM, index, verdict
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      idx     <= '0;
      err_idx <= '0;
      pass_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (clear) begin
      state   <= S_CHECK;
      idx     <= '0;
      err_idx <= '0;
      pass_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        S_CHECK: begin
          if (beat) begin
            if (beat_ok) begin
              idx <= idx + CW'(1);
              if (idx == CW'(N_TERMS - 1)) begin
                pass_r <= 1'b1;
                state  <= S_REPORT;
              end
            end else begin
              err_r   <= 1'b1;
              err_idx <= idx;
              state   <= S_REPORT;
            end
          end
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Data: term history, cleared on every run start
  always_ff @(posedge CLK) begin
    if (clear) begin
      prev1 <= '0;
      prev2 <= '0;
    end else if (beat && beat_ok) begin
      prev2 <= prev1;
      prev1 <= DATA_IN;
    end
  end

  assign BUSY    = (state == S_CHECK);
  assign DONE    = (state == S_REPORT);
  assign PASS    = pass_r;
  assign ERR     = err_r;
  assign ERR_IDX = err_idx;
  assign COUNT   = idx;

endmodule

// File: tb/tb_fib_seq_checker.sv
module tb_fib_seq_checker;

  localparam int W  = 11;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          valid;
  logic [W-1:0]  data_in;

  logic          busy_a, done_a, pass_a, err_a;
  logic [CW-1:0] err_idx_a, count_a;
  logic          busy_b, done_b, pass_b, err_b;
  logic [CW-1:0] err_idx_b, count_b;

  int checks = 0;
  int errors = 0;

  int fib [0:18] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377,
                     610, 987, 1597, 536};
  int lucas [0:15] = '{2, 1, 3, 4, 7, 11, 18, 29, 47, 76, 123, 199, 322,
                       521, 843, 1364};

  always #5 clk = ~clk;

  fib_seq_checker #(.W(W), .N_TERMS(16)) dut_a (
    .CLK(clk), .RST_N(rst_n), .START(start), .VALID(valid), .DATA_IN(data_in),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR(err_a),
    .ERR_IDX(err_idx_a), .COUNT(count_a)
  );

  fib_seq_checker #(.W(W), .N_TERMS(19)) dut_b (
    .CLK(clk), .RST_N(rst_n), .START(start), .VALID(valid), .DATA_IN(data_in),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR(err_b),
    .ERR_IDX(err_idx_b), .COUNT(count_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int v, input int gap);
    valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    valid   = 1'b1;
    data_in = W'(v);
    tick();
    valid   = 1'b0;
  endtask

  task automatic chk_outs_a(input string tag, input int bsy, input int dn,
                            input int ps, input int er, input int ei,
                            input int cnt);
    chk({tag, ".busy"},    busy_a,    bsy);
    chk({tag, ".done"},    done_a,    dn);
    chk({tag, ".pass"},    pass_a,    ps);
    chk({tag, ".err"},     err_a,     er);
    chk({tag, ".err_idx"}, err_idx_a, ei);
    chk({tag, ".count"},   count_a,   cnt);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; data_in = '0;
    tick(); tick();
    chk_outs_a("por", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Reset mid-run
    do_start();
    chk("rst_run.busy", busy_a, 1);
    send(0, 0); send(1, 0); send(1, 0);
    chk("rst_run.count", count_a, 3);
    rst_n = 1'b0;
    tick();
    chk_outs_a("rst_mid", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    send(0, 0); send(1, 1);
    chk_outs_a("idle_beats", 0, 0, 0, 0, 0, 0);

    // Good stream with random gaps
    do_start();
    for (int i = 0; i < 15; i++) begin
      send(fib[i], $urandom_range(0, 2));
      chk("good.done_early", done_a, 0);
      chk("good.busy", busy_a, 1);
    end
    send(fib[15], $urandom_range(0, 2));
    chk_outs_a("good_end", 0, 1, 1, 0, 0, 16);
    tick();
    chk_outs_a("good_after", 0, 0, 1, 0, 0, 16);
    tick(); tick();
    chk("good.pass_hold", pass_a, 1);

    // Corrupt term at idx 7
    do_start();
    chk_outs_a("corrupt_start", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) send(fib[i], $urandom_range(0, 1));
    send(14, 0);
    chk_outs_a("corrupt_end", 0, 1, 0, 1, 7, 7);
    for (int i = 8; i < 16; i++) send(fib[i], 0);
    chk_outs_a("corrupt_after", 0, 0, 0, 1, 7, 7);

    // Restart with a same-cycle beat
    do_start();
    for (int i = 0; i < 5; i++) send(fib[i], 0);
    chk("restart.count5", count_a, 5);
    start   = 1'b1;
    valid   = 1'b1;
    data_in = W'(fib[5]);
    tick();
    start = 1'b0;
    valid = 1'b0;
    chk("restart.count0", count_a, 0);
    chk("restart.busy", busy_a, 1);
    for (int i = 0; i < 16; i++) send(fib[i], $urandom_range(0, 1));
    chk_outs_a("restart_end", 0, 1, 1, 0, 0, 16);

    // Overflow at idx 18 on the 19-term checker
    do_start();
    chk("ovf.busy", busy_b, 1);
    for (int i = 0; i < 18; i++) send(fib[i], 0);
    chk("ovf.count18", count_b, 18);
    send(fib[18], 0);
    chk("ovf.done", done_b, 1);
    chk("ovf.err", err_b, 1);
    chk("ovf.pass", pass_b, 0);
    chk("ovf.err_idx", err_idx_b, 18);
    chk("ovf.count", count_b, 18);
    tick();

    // Arbitrary seeds
    do_start();
`ifdef FIB_CHK_SEED_EN
    for (int i = 0; i < 16; i++) send(lucas[i], 0);
    chk_outs_a("seed_end", 0, 1, 1, 0, 0, 16);
`else
    send(lucas[0], 0);
    chk_outs_a("seed_end", 0, 1, 0, 1, 0, 0);
    for (int i = 1; i < 4; i++) send(lucas[i], 0);
    chk_outs_a("seed_after", 0, 0, 0, 1, 0, 0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
